matrix_stream_sink: RTL and testbench

MATRIX_STREAM_SINK -- requirements
Module: matrix_stream_sink

---
 rtl/matrix_stream_sink_pkg.sv | 23 ++
 rtl/matrix_stream_sink_if.sv | 32 +++
 rtl/matrix_stream_sink_range.sv | 34 +++
 rtl/matrix_stream_sink.sv | 135 +++++++++++++
 tb/tb_matrix_stream_sink.sv | 233 +++++++++++++++++++++++
 5 files changed

// File: rtl/matrix_stream_sink_pkg.sv
// Shared definitions for the matrix stream sink: limits, address width and FSM states.
package matrix_pkg;

  localparam int MAX_DIM             = 5;
  localparam int MAX_COUNT           = 15;
  localparam int SLOT_STRIDE_DEFAULT = 32;
  localparam int ADDR_W              = 9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RECV = 2'd1,
    ST_DONE = 2'd2
  } sink_state_e;

  // A run needs both dimensions in 1..MAX_DIM and at least one matrix.
  function automatic logic cfg_legal(input logic [2:0] m, input logic [2:0] n,
                                     input logic [3:0] c);
    return (m != 3'd0) && (m <= 3'(MAX_DIM)) &&
           (n != 3'd0) && (n <= 3'(MAX_DIM)) &&
           (c != 4'd0) && (c <= 4'(MAX_COUNT));
  endfunction

endpackage

// File: rtl/matrix_stream_sink_if.sv
// Bundles the run configuration, element stream, storage write port and status of the sink.
interface matrix_stream_sink_if import matrix_pkg::*; ();

  logic                start_rx;
  logic [2:0]          dim_m;
  logic [2:0]          dim_n;
  logic [3:0]          count;
  logic signed [7:0]   elem_min_cfg;
  logic signed [7:0]   elem_max_cfg;
  logic [7:0]          data_in;
  logic                write_en;

  logic                mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [7:0]          mem_wdata;
  logic                rx_busy;
  logic                rx_done;
  logic                rx_timeout;
  logic                cfg_err;
  logic [7:0]          err_cnt;

  modport master (
    output start_rx, dim_m, dim_n, count, elem_min_cfg, elem_max_cfg, data_in, write_en,
    input  mem_we, mem_addr, mem_wdata, rx_busy, rx_done, rx_timeout, cfg_err, err_cnt
  );

  modport slave (
    input  start_rx, dim_m, dim_n, count, elem_min_cfg, elem_max_cfg, data_in, write_en,
    output mem_we, mem_addr, mem_wdata, rx_busy, rx_done, rx_timeout, cfg_err, err_cnt
  );

endinterface

// File: rtl/matrix_stream_sink_range.sv
// Signed element range checker with a saturating violation counter, cleared on each run start.
module mat_range_check (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic signed [7:0] min_cfg,
  input  logic signed [7:0] max_cfg,
  input  logic              check_en,
  input  logic signed [7:0] data,
  output logic [7:0]        err_cnt
);

  logic signed [7:0] min_q;
  logic signed [7:0] max_q;
  logic              violation;

  assign violation = (data < min_q) || (data > max_q);

  // Bounds are captured at run start so mid-run config changes have no effect.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      min_q   <= '0;
      max_q   <= '0;
      err_cnt <= '0;
    end else if (load) begin
      min_q   <= min_cfg;
      max_q   <= max_cfg;
      err_cnt <= '0;
    end else if (check_en && violation && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'd1;
    end
  end

endmodule

// File: rtl/matrix_stream_sink.sv
// Receives count matrices of dim_m x dim_n bytes into slotted storage with idle timeout.
// Optional range checking is built when MATRIX_SINK_RANGE_CHECK_EN is defined.
module matrix_stream_sink import matrix_pkg::*; #(
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int SLOT_STRIDE    = SLOT_STRIDE_DEFAULT
) (
  input logic                 clk,
  input logic                 rst,
  matrix_stream_sink_if.slave bus
);

  localparam int IDLE_W = $clog2(TIMEOUT_CYCLES) + 1;

  sink_state_e       state;
  logic [4:0]        elem_total;
  logic [4:0]        elem_idx;
  logic [3:0]        count_q;
  logic [3:0]        slot;
  logic [IDLE_W-1:0] idle_cnt;

  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [7:0]        mem_wdata_q;
  logic              rx_busy_q;
  logic              rx_done_q;
  logic              rx_timeout_q;
  logic              cfg_err_q;

  logic              accept;
  logic              start_ok;
  logic              run_load;
  logic              last_in_slot;
  logic              last_elem;

  assign accept       = (state == ST_RECV) && bus.write_en;
  assign start_ok     = cfg_legal(bus.dim_m, bus.dim_n, bus.count);
  assign run_load     = (state == ST_IDLE) && bus.start_rx && start_ok;
  assign last_in_slot = (elem_idx == elem_total - 5'd1);
  assign last_elem    = last_in_slot && (slot == count_q - 4'd1);

  // Write port and status flags are registered, so a write appears one cycle after acceptance.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      elem_total   <= '0;
      elem_idx     <= '0;
      count_q      <= '0;
      slot         <= '0;
      idle_cnt     <= '0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      rx_busy_q    <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_timeout_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      mem_we_q     <= 1'b0;
      rx_done_q    <= 1'b0;
      rx_timeout_q <= 1'b0;
      cfg_err_q    <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start_rx) begin
            if (start_ok) begin
              state      <= ST_RECV;
              elem_total <= 5'(bus.dim_m) * 5'(bus.dim_n);
              count_q    <= bus.count;
              elem_idx   <= '0;
              slot       <= '0;
              idle_cnt   <= '0;
              rx_busy_q  <= 1'b1;
            end else begin
              cfg_err_q  <= 1'b1;
            end
          end
        end
        ST_RECV: begin
          if (bus.write_en) begin
            mem_we_q    <= 1'b1;
            mem_wdata_q <= bus.data_in;
            mem_addr_q  <= ADDR_W'(slot) * ADDR_W'(SLOT_STRIDE) + ADDR_W'(elem_idx);
            idle_cnt    <= '0;
            if (last_in_slot) begin
              elem_idx <= '0;
              slot     <= slot + 4'd1;
            end else begin
              elem_idx <= elem_idx + 5'd1;
            end
            if (last_elem) begin
              state     <= ST_DONE;
              rx_busy_q <= 1'b0;
              rx_done_q <= 1'b1;
            end
          end else if (idle_cnt == IDLE_W'(TIMEOUT_CYCLES - 1)) begin
            state        <= ST_IDLE;
            rx_busy_q    <= 1'b0;
            rx_timeout_q <= 1'b1;
          end else begin
            idle_cnt <= idle_cnt + IDLE_W'(1);
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.mem_we     = mem_we_q;
  assign bus.mem_addr   = mem_addr_q;
  assign bus.mem_wdata  = mem_wdata_q;
  assign bus.rx_busy    = rx_busy_q;
  assign bus.rx_done    = rx_done_q;
  assign bus.rx_timeout = rx_timeout_q;
  assign bus.cfg_err    = cfg_err_q;

`ifdef MATRIX_SINK_RANGE_CHECK_EN
  mat_range_check u_range_check (
    .clk      (clk),
    .rst      (rst),
    .load     (run_load),
    .min_cfg  (bus.elem_min_cfg),
    .max_cfg  (bus.elem_max_cfg),
    .check_en (accept),
    .data     ($signed(bus.data_in)),
    .err_cnt  (bus.err_cnt)
  );
`else
  // Without the checker the bounds and start/accept strobes have no consumer.
  logic unused_range_inputs;
  assign unused_range_inputs = ^{bus.elem_min_cfg, bus.elem_max_cfg, run_load, accept};
  assign bus.err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_matrix_stream_sink.sv
// Scoreboard bench for matrix_stream_sink: expected writes are queued, a monitor checks them.
module tb_matrix_stream_sink;
  import matrix_pkg::*;

  typedef struct {
    int addr;
    int data;
    int done;
  } wr_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   doneCount;
  int   timeoutCount;
  int   cfgErrCount;
  wr_t  expQ[$];

  matrix_stream_sink_if bus();

  matrix_stream_sink #(
    .TIMEOUT_CYCLES (16),
    .SLOT_STRIDE    (32)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef MATRIX_SINK_RANGE_CHECK_EN
  localparam int RANGE_ON = 1;
`else
  localparam int RANGE_ON = 0;
`endif

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expectWrite(input int addr, input int data, input int done);
    wr_t w;
    w.addr = addr;
    w.data = data;
    w.done = done;
    expQ.push_back(w);
  endtask

  // Drives one element for exactly one cycle.
  task automatic applyStimulus(input logic [7:0] d);
    bus.write_en = 1'b1;
    bus.data_in  = d;
    tick();
    bus.write_en = 1'b0;
  endtask

  task automatic startRun(input logic [2:0] m, input logic [2:0] n, input logic [3:0] c,
                          input logic signed [7:0] lo, input logic signed [7:0] hi);
    bus.dim_m        = m;
    bus.dim_n        = n;
    bus.count        = c;
    bus.elem_min_cfg = lo;
    bus.elem_max_cfg = hi;
    bus.start_rx     = 1'b1;
    tick();
    bus.start_rx     = 1'b0;
  endtask

  // Monitor: every write strobe must match the head of the expected queue.
  initial begin
    wr_t w;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (bus.rx_done) doneCount++;
        if (bus.rx_timeout) timeoutCount++;
        if (bus.cfg_err) cfgErrCount++;
        if (bus.rx_done && !bus.mem_we) checkOutput("done_without_write", 1, 0);
        if (bus.mem_we) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpected_write_addr", int'(bus.mem_addr), -1);
          end else begin
            w = expQ.pop_front();
            checkOutput("write_addr", int'(bus.mem_addr), w.addr);
            checkOutput("write_data", int'(bus.mem_wdata), w.data);
            checkOutput("write_done_flag", int'(bus.rx_done), w.done);
          end
        end
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int seen;
    checks = 0; errors = 0; doneCount = 0; timeoutCount = 0; cfgErrCount = 0;
    rst = 1'b1;
    bus.start_rx = 1'b0; bus.dim_m = '0; bus.dim_n = '0; bus.count = '0;
    bus.elem_min_cfg = '0; bus.elem_max_cfg = '0; bus.data_in = '0; bus.write_en = 1'b0;
    tick(); tick();

    checkOutput("reset_mem_we", int'(bus.mem_we), 0);
    checkOutput("reset_mem_addr", int'(bus.mem_addr), 0);
    checkOutput("reset_rx_busy", int'(bus.rx_busy), 0);
    checkOutput("reset_rx_done", int'(bus.rx_done), 0);
    checkOutput("reset_rx_timeout", int'(bus.rx_timeout), 0);
    checkOutput("reset_cfg_err", int'(bus.cfg_err), 0);
    checkOutput("reset_err_cnt", int'(bus.err_cnt), 0);
    rst = 1'b0;
    tick();

    $display("[TB] 2x3 x2 back-to-back");
    startRun(3'd2, 3'd3, 4'd2, -8'sd128, 8'sd127);
    checkOutput("busy_after_start", int'(bus.rx_busy), 1);
    for (int i = 0; i < 12; i++)
      expectWrite((i / 6) * 32 + (i % 6), i + 1, (i == 11) ? 1 : 0);
    for (int i = 0; i < 12; i++) applyStimulus(8'(i + 1));
    checkOutput("busy_in_done_cycle", int'(bus.rx_busy), 0);
    tick();

    $display("[TB] illegal configurations");
    startRun(3'd0, 3'd3, 4'd1, -8'sd128, 8'sd127);
    checkOutput("cfg_err_dim_m0", int'(bus.cfg_err), 1);
    checkOutput("busy_after_reject", int'(bus.rx_busy), 0);
    applyStimulus(8'h55);
    startRun(3'd2, 3'd2, 4'd0, -8'sd128, 8'sd127);
    checkOutput("cfg_err_count0", int'(bus.cfg_err), 1);
    startRun(3'd6, 3'd1, 4'd1, -8'sd128, 8'sd127);
    checkOutput("cfg_err_dim6", int'(bus.cfg_err), 1);
    tick();
    checkOutput("cfg_err_pulse_width", int'(bus.cfg_err), 0);
    checkOutput("cfg_err_total", cfgErrCount, 3);

    $display("[TB] 1x1 x15 slot stride");
    startRun(3'd1, 3'd1, 4'd15, -8'sd128, 8'sd127);
    for (int i = 0; i < 15; i++) expectWrite(i * 32, 8'h80 + i, (i == 14) ? 1 : 0);
    for (int i = 0; i < 15; i++) applyStimulus(8'(8'h80 + i));
    tick();

    $display("[TB] timeout 2x2 after 3 elements");
    startRun(3'd2, 3'd2, 4'd1, -8'sd128, 8'sd127);
    for (int i = 0; i < 3; i++) expectWrite(i, 8'h20 + i, 0);
    seen = doneCount;
    for (int i = 0; i < 3; i++) applyStimulus(8'(8'h20 + i));
    begin
      int latency;
      latency = -1;
      for (int k = 1; k <= 40; k++) begin
        tick();
        if (bus.rx_timeout && latency < 0) latency = k;
      end
      checkOutput("timeout_latency", latency, 16);
    end
    checkOutput("busy_after_timeout", int'(bus.rx_busy), 0);
    checkOutput("no_done_on_timeout", doneCount, seen);
    checkOutput("timeout_total", timeoutCount, 1);

    $display("[TB] range check [-5,5]");
    startRun(3'd2, 3'd2, 4'd1, -8'sd5, 8'sd5);
    expectWrite(0, 8'h07, 0); expectWrite(1, 8'hFA, 0);
    expectWrite(2, 8'h00, 0); expectWrite(3, 8'h05, 1);
    applyStimulus(8'h07); applyStimulus(8'hFA); applyStimulus(8'h00); applyStimulus(8'h05);
    checkOutput("range_err_cnt", int'(bus.err_cnt), RANGE_ON ? 2 : 0);
    tick();
    checkOutput("range_err_cnt_held", int'(bus.err_cnt), RANGE_ON ? 2 : 0);

    $display("[TB] reset mid-run 3x3");
    startRun(3'd3, 3'd3, 4'd1, 8'sd0, 8'sd10);
    checkOutput("range_err_cleared_on_start", int'(bus.err_cnt), 0);
    expectWrite(0, 20, 0); expectWrite(1, 1, 0); expectWrite(2, 2, 0); expectWrite(3, 30, 0);
    applyStimulus(8'd20); applyStimulus(8'd1); applyStimulus(8'd2); applyStimulus(8'd30);
    tick();
    checkOutput("pre_reset_addr", int'(bus.mem_addr), 3);
    checkOutput("pre_reset_err_cnt", int'(bus.err_cnt), RANGE_ON ? 2 : 0);
    seen = doneCount;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_busy", int'(bus.rx_busy), 0);
    checkOutput("midrun_reset_addr", int'(bus.mem_addr), 0);
    checkOutput("midrun_reset_err_cnt", int'(bus.err_cnt), 0);
    checkOutput("midrun_reset_mem_we", int'(bus.mem_we), 0);
    #4;
    rst = 1'b0;
    startRun(3'd1, 3'd1, 4'd1, -8'sd128, 8'sd127);
    checkOutput("busy_first_edge_after_reset", int'(bus.rx_busy), 1);
    checkOutput("no_done_from_reset", doneCount, seen);
    expectWrite(0, 8'h5A, 1);
    applyStimulus(8'h5A);
    tick();

    $display("[TB] ignored write_en and start_rx");
    applyStimulus(8'hAA);
    checkOutput("idle_write_ignored", int'(bus.mem_we), 0);
    tick();
    startRun(3'd1, 3'd2, 4'd2, -8'sd128, 8'sd127);
    expectWrite(0, 8'h11, 0); expectWrite(1, 8'h22, 0);
    expectWrite(32, 8'h33, 0); expectWrite(33, 8'h44, 1);
    applyStimulus(8'h11);
    startRun(3'd3, 3'd3, 4'd1, -8'sd128, 8'sd127);
    checkOutput("recv_start_ignored_busy", int'(bus.rx_busy), 1);
    applyStimulus(8'h22); applyStimulus(8'h33); applyStimulus(8'h44);
    startRun(3'd2, 3'd2, 4'd1, -8'sd128, 8'sd127);
    tick();
    checkOutput("done_start_ignored_busy", int'(bus.rx_busy), 0);

    tick(); tick();
    checkOutput("queue_drained", expQ.size(), 0);
    checkOutput("done_total", doneCount, 5);
    checkOutput("cfg_err_final", cfgErrCount, 3);
    checkOutput("timeout_final", timeoutCount, 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
